// File: rtl/add8_err_monitor_if.sv
// add8_err_monitor_if: sample-stream and snapshot-readout bundle for
// add8_err_monitor.
//   Sample side : in_valid/in_ready handshake, in_a/in_b operands, in_o result.
//   Control     : clear (zero live stats), snap_req (request snapshot).
//   Readout     : snap_valid/snap_ready handshake and frozen snap_* values.
// Modports: master = sample/host driver, slave = monitor.
interface add8_err_monitor_if #(
  parameter int CNT_W = 17,
  parameter int SAE_W = 26,
  parameter int SSE_W = 35
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [8:0]       in_o;
  logic             clear;
  logic             snap_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [CNT_W-1:0] snap_n;
  logic [CNT_W-1:0] snap_nerr;
  logic [SAE_W-1:0] snap_sae;
  logic [SSE_W-1:0] snap_sse;
  logic [8:0]       snap_wce;
  logic             snap_sat;

  modport master (
    output in_valid, in_a, in_b, in_o, clear, snap_req, snap_ready,
    input  in_ready, snap_valid, snap_n, snap_nerr, snap_sae, snap_sse,
           snap_wce, snap_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_o, clear, snap_req, snap_ready,
    output in_ready, snap_valid, snap_n, snap_nerr, snap_sae, snap_sse,
           snap_wce, snap_sat
  );
endinterface

// File: rtl/add8_err_monitor.sv
// add8_err_monitor: accumulates error statistics of an 8-bit approximate
// adder (sample count, erroneous count, sum |e|, sum e^2, worst |e|) and
// hands frozen snapshots to a host.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - add8_err_monitor_if.slave (sample stream, clear, snapshot readout)
// Optional feature: define ADD8_ERR_MONITOR_SSE_EN to build the squarer and
// the sum-of-squared-error accumulator; otherwise snap_sse reads 0.
module add8_err_monitor #(
  parameter int CNT_W = 17,
  parameter int SAE_W = 26,
  parameter int SSE_W = 35
) (
  input  logic              clk,
  input  logic              rst_n,
  add8_err_monitor_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

  state_t           state_q;
  logic [1:0]       drain_cnt_q;
  logic             in_ready_q;
  logic             snap_valid_q;

  logic             s1_v_q, s2_v_q, s2_flag_q;
  logic [8:0]       s1_e_q, s2_e_q;

  logic [CNT_W-1:0] n_q, nerr_q, snap_n_q, snap_nerr_q;
  logic [SAE_W-1:0] sae_q, snap_sae_q;
  logic [8:0]       wce_q, snap_wce_q;
  logic             sat_q, snap_sat_q;

  logic             accept;
  logic [8:0]       exact, e;
  logic [CNT_W:0]   n_sum, nerr_sum;
  logic [SAE_W:0]   sae_sum;
  logic [CNT_W-1:0] n_d, nerr_d;
  logic [SAE_W-1:0] sae_d;
  logic [8:0]       wce_d;
  logic             sat_hit;

`ifdef ADD8_ERR_MONITOR_SSE_EN
  logic [17:0]      s2_sq_q;
  logic [SSE_W-1:0] sse_q, snap_sse_q, sse_d;
  logic [SSE_W:0]   sse_sum;
`endif

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    exact = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    e     = (bus.in_o >= exact) ? (bus.in_o - exact) : (exact - bus.in_o);
  end

  // Each accumulator clamps at all-ones; the carry-out flags the clamp.
  always_comb begin
    n_sum    = {1'b0, n_q} + (CNT_W+1)'(1);
    nerr_sum = {1'b0, nerr_q} + (CNT_W+1)'(s2_flag_q);
    sae_sum  = {1'b0, sae_q} + (SAE_W+1)'(s2_e_q);
    n_d      = n_sum[CNT_W]    ? '1 : n_sum[CNT_W-1:0];
    nerr_d   = nerr_sum[CNT_W] ? '1 : nerr_sum[CNT_W-1:0];
    sae_d    = sae_sum[SAE_W]  ? '1 : sae_sum[SAE_W-1:0];
    wce_d    = (s2_e_q > wce_q) ? s2_e_q : wce_q;
    sat_hit  = n_sum[CNT_W] | nerr_sum[CNT_W] | sae_sum[SAE_W];
`ifdef ADD8_ERR_MONITOR_SSE_EN
    sse_sum  = {1'b0, sse_q} + (SSE_W+1)'(s2_sq_q);
    sse_d    = sse_sum[SSE_W] ? '1 : sse_sum[SSE_W-1:0];
    sat_hit  = sat_hit | sse_sum[SSE_W];
`endif
  end

  // Pipeline. A sample accepted alongside clear still enters S1; clear only
  // kills what was already in S1 (by not promoting it) and S2 (by zeroing
  // the accumulators instead of updating them).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_e_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_e_q    <= '0;
      s2_flag_q <= 1'b0;
`ifdef ADD8_ERR_MONITOR_SSE_EN
      s2_sq_q   <= '0;
`endif
    end else begin
      s1_v_q    <= accept;
      s1_e_q    <= e;
      s2_v_q    <= s1_v_q && !bus.clear;
      s2_e_q    <= s1_e_q;
      s2_flag_q <= |s1_e_q;
`ifdef ADD8_ERR_MONITOR_SSE_EN
      s2_sq_q   <= 18'(s1_e_q) * 18'(s1_e_q);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      nerr_q <= '0;
      sae_q  <= '0;
      wce_q  <= '0;
      sat_q  <= 1'b0;
`ifdef ADD8_ERR_MONITOR_SSE_EN
      sse_q  <= '0;
`endif
    end else if (bus.clear) begin
      n_q    <= '0;
      nerr_q <= '0;
      sae_q  <= '0;
      wce_q  <= '0;
      sat_q  <= 1'b0;
`ifdef ADD8_ERR_MONITOR_SSE_EN
      sse_q  <= '0;
`endif
    end else if (s2_v_q) begin
      n_q    <= n_d;
      nerr_q <= nerr_d;
      sae_q  <= sae_d;
      wce_q  <= wce_d;
      sat_q  <= sat_q | sat_hit;
`ifdef ADD8_ERR_MONITOR_SSE_EN
      sse_q  <= sse_d;
`endif
    end
  end

  // Snapshot FSM. DRAIN lasts three edges so the sample accepted with
  // snap_req has reached the accumulators before the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      drain_cnt_q  <= '0;
      in_ready_q   <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_n_q     <= '0;
      snap_nerr_q  <= '0;
      snap_sae_q   <= '0;
      snap_wce_q   <= '0;
      snap_sat_q   <= 1'b0;
`ifdef ADD8_ERR_MONITOR_SSE_EN
      snap_sse_q   <= '0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          in_ready_q <= 1'b1;
          if (bus.snap_req) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == 2'd2) begin
            state_q      <= HOLD;
            snap_valid_q <= 1'b1;
            snap_n_q     <= n_q;
            snap_nerr_q  <= nerr_q;
            snap_sae_q   <= sae_q;
            snap_wce_q   <= wce_q;
            snap_sat_q   <= sat_q;
`ifdef ADD8_ERR_MONITOR_SSE_EN
            snap_sse_q   <= sse_q;
`endif
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        HOLD: begin
          if (snap_valid_q && bus.snap_ready) begin
            state_q      <= RUN;
            snap_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= RUN;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.snap_n     = snap_n_q;
  assign bus.snap_nerr  = snap_nerr_q;
  assign bus.snap_sae   = snap_sae_q;
  assign bus.snap_wce   = snap_wce_q;
  assign bus.snap_sat   = snap_sat_q;
`ifdef ADD8_ERR_MONITOR_SSE_EN
  assign bus.snap_sse   = snap_sse_q;
`else
  assign bus.snap_sse   = {SSE_W{1'b0}};
`endif

endmodule

// File: doc/add8_err_monitor.md
# add8_err_monitor

Streaming error-characterisation block that consumes operand/result triples from an 8-bit approximate adder under test and accumulates its error statistics in hardware: sample count, erroneous-sample count, sum of absolute error, sum of squared error and worst-case error. It sits on the output side of an approximate adder instance in the evaluation fabric. It receives the adder's 9-bit result and delivers frozen statistics snapshots to a host readout over a valid/ready handshake.

## Interface
- `CNT_W`, default 17: width of the sample and error counters; 17 covers the full 65536-pair operand space.
- `SAE_W`, default 26: width of the sum-of-absolute-error accumulator, at least `CNT_W+9`.
- `SSE_W`, default 35: width of the sum-of-squared-error accumulator, at least `CNT_W+18`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: sample accepted when `in_valid && in_ready` at an edge.
- `in_a`, `in_b` in 8 each: operands applied to the adder under test.
- `in_o` in 9: approximate sum produced by the adder under test.
- `clear` in 1: single-cycle pulse that zeroes the live accumulators.
- `snap_req` in 1: single-cycle pulse that requests a snapshot.
- `snap_valid` out 1: snapshot outputs are stable and valid.
- `snap_ready` in 1: host consumes the snapshot.
- `snap_n` out `CNT_W`: samples accepted.
- `snap_nerr` out `CNT_W`: samples with nonzero error.
- `snap_sae` out `SAE_W`: sum of |in_o − (in_a+in_b)|.
- `snap_sse` out `SSE_W`: sum of squared error.
- `snap_wce` out 9: maximum absolute error.
- `snap_sat` out 1: sticky flag, set when any accumulator has saturated.

## Operation
- Error per sample: exact = zero-extended `in_a + in_b` (9 bits); e = |`in_o` − exact|, 9 bits, range 0..511.
- 3-stage pipeline:
  - S1 registers e.
  - S2 registers e, e², and the flag (e≠0).
  - Edge 3 updates the accumulators: n+1, nerr+flag, sae+e, sse+e², wce=max(wce,e).
- Saturation: each counter or accumulator clamps at all-ones instead of wrapping. Any clamp sets the live sat flag; `clear` resets it.
- FSM states:
  - RUN: `in_ready`=1.
  - DRAIN: `in_ready`=0, fixed 3 cycles, counted by a 2-bit counter.
  - HOLD: `in_ready`=0, `snap_valid`=1.
- Transitions:
  - RUN→DRAIN when `snap_req`=1. A sample accepted in that same cycle is included in the snapshot.
  - DRAIN→HOLD after 3 cycles. The snapshot registers copy the live accumulators on that edge.
  - HOLD→RUN on `snap_valid && snap_ready`.
- `clear` in any state:
  - Zeroes the live accumulators and the sat flag, and invalidates S1/S2 contents.
  - Does not alter the snapshot registers or the FSM state.
  - A sample accepted in the same cycle as `clear` enters S1 and is counted.
- `clear` and the final accumulate edge coincide: `clear` wins, and that in-flight update is discarded.
- `snap_req` outside RUN is ignored.
- Reset mid-operation: everything returns to the reset state, and any in-flight snapshot is lost.

## Timing
- Reset values: state RUN; `in_ready`=0 during reset, then 1 from the first edge after `rst_n` rises. `snap_valid`=0; all `snap_*` = 0; live accumulators, S1/S2 valid bits and the sat flag = 0.
- All outputs are registered.
- Accumulator latency: a sample accepted at edge E is reflected in the accumulators after edge E+2.
- Snapshot latency: `snap_req` sampled at edge E0 gives `snap_valid`=1 after edge E0+3. `in_ready` is 0 after edge E0.
- `snap_*` outputs are held stable while `snap_valid`=1. `snap_valid` falls on the edge where `snap_ready`=1, and `in_ready` rises on that same edge.

## Configuration
- `ADD8_ERR_MONITOR_SSE_EN` defined:
  - S2 contains the 9×9 squarer.
  - The SSE accumulator is live and its saturation contributes to `snap_sat`.
- Not defined:
  - No squarer and no SSE register.
  - `snap_sse` is tied to 0.
  - Latency and handshake timing are unchanged; S2 still exists.

## Test plan
- Reset then idle: `snap_req` → after 3 cycles `snap_valid`=1 with n=0, nerr=0, sae=0, sse=0, wce=0, sat=0; `snap_ready`=1 → `in_ready`=1 on the next cycle.
- Exact samples: (0x10,0x20,0x030) and (0xFF,0xFF,0x1FE), then snapshot → n=2, nerr=0, sae=0, wce=0.
- Errors: (0xFF,0x01,0x0F0) gives e=16; (0x05,0x03,0x001) gives e=7. Snapshot → n=2, nerr=2, sae=23, sse=305 (0 without the macro), wce=16.
- Boundary: `snap_req` in the same cycle as an accepted sample with e=23 → that sample is included in the snapshot (sae=23); `in_valid` held high during DRAIN/HOLD is not accepted.
- Clear race: accept 3 error samples back-to-back, pulse `clear` on the edge after the third, then snapshot → n=0, sae=0. Separately, `clear` together with a new accepted sample with e=5 → n=1, sae=5.
- Saturation: with `CNT_W`=4, feed 20 samples with e=511 → n=15, nerr=15, sae at `SAE_W` maximum or the exact sum, `snap_sat`=1; `clear` then snapshot → sat=0.
